// File: rtl/btb_pkg.sv
// Shared constants, entry layout and PC field helpers for the branch target buffer.
package btb_pkg;

  localparam int ADDR_W      = 64;
  localparam int ENTRIES     = 16;
  localparam int IDX_W       = $clog2(ENTRIES);
  localparam int TAG_W       = ADDR_W - IDX_W - 2;
  localparam int CNT_W       = 2;
  localparam int INSTR_BYTES = 4;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } btb_entry_t;

  function automatic logic [IDX_W-1:0] btb_index(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state of a saturating direction counter for one training event.
module btb_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  input  logic             uncond,
  output logic [CNT_W-1:0] nextCnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Unconditional branches jump straight to strongly taken.
  always_comb begin
    nextCnt = cnt;
    if (uncond) begin
      nextCnt = CntMax;
    end else if (taken) begin
      if (cnt != CntMax) nextCnt = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) nextCnt = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters,
// zero-latency lookup, one-cycle training port, global flush and saturating stats.
module btb_predictor #(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic              update_uncond,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              flush_all,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits
);

  import btb_pkg::*;

  localparam int IdxW = $clog2(ENTRIES);
  localparam int TagW = ADDR_W - IdxW - 2;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntWeak = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic              valid;
    logic [TagW-1:0]   tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  entry_t entries [ENTRIES];

  logic [IdxW-1:0] lookupIdx;
  logic [TagW-1:0] lookupTag;
  logic [IdxW-1:0] updIdx;
  logic [TagW-1:0] updTag;
  entry_t          lookupEntry;
  entry_t          updEntry;
  logic            updHit;
  logic [CNT_W-1:0] nextCnt;
  logic            unusedBits;

  assign lookupIdx  = lookup_pc[IdxW+1:2];
  assign lookupTag  = lookup_pc[ADDR_W-1:IdxW+2];
  assign updIdx     = update_pc[IdxW+1:2];
  assign updTag     = update_pc[ADDR_W-1:IdxW+2];
  assign unusedBits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lookupEntry = entries[lookupIdx];
  assign updEntry    = entries[updIdx];
  assign updHit      = updEntry.valid && (updEntry.tag == updTag);

  // Prediction reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit     = lookupEntry.valid && (lookupEntry.tag == lookupTag);
    pred_taken   = pred_hit && lookupEntry.cnt[CNT_W-1];
    pred_next_pc = pred_taken ? lookupEntry.target
                              : lookup_pc + ADDR_W'(INSTR_BYTES);
  end

  btb_sat_counter #(
    .CNT_W(CNT_W)
  ) uSatCounter (
    .cnt    (updEntry.cnt),
    .taken  (update_taken),
    .uncond (update_uncond),
    .nextCnt(nextCnt)
  );

  // Flush wins over training; a miss allocates only on a taken branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
    end else if (update_valid) begin
      if (updHit) begin
        entries[updIdx].cnt <= nextCnt;
        if (update_taken) entries[updIdx].target <= update_target;
      end else if (update_taken) begin
        entries[updIdx].valid  <= 1'b1;
        entries[updIdx].tag    <= updTag;
        entries[updIdx].target <= update_target;
        entries[updIdx].cnt    <= update_uncond ? CntMax : CntWeak;
      end
    end
  end

  // Performance counters stick at all ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
    end else if (lookup_valid) begin
      if (stat_lookups != '1) stat_lookups <= stat_lookups + STAT_W'(1);
      if (pred_hit && (stat_hits != '1)) stat_hits <= stat_hits + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: directed training/lookup vectors, monitor checks each lookup.
module tb_btb_predictor;

  localparam int ADDR_W  = 64;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int STAT_W  = 32;

  logic              clk = 1'b0;
  logic              clkEn = 1'b1;
  logic              reset;
  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic              update_taken;
  logic              update_uncond;
  logic [ADDR_W-1:0] update_target;
  logic              flush_all;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_hits;

  typedef struct {
    logic              hit;
    logic              taken;
    logic [ADDR_W-1:0] nextPc;
    logic [ADDR_W-1:0] pc;
  } expect_t;

  expect_t scoreboard[$];
  int total = 0;
  int bad = 0;
  int expLookups = 0;
  int expHits = 0;

  btb_predictor #(
    .ADDR_W (ADDR_W),
    .ENTRIES(ENTRIES),
    .CNT_W  (CNT_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_next_pc (pred_next_pc),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_uncond(update_uncond),
    .update_target(update_target),
    .flush_all    (flush_all),
    .stat_lookups (stat_lookups),
    .stat_hits    (stat_hits)
  );

  // Gated clock so reset can be exercised with the clock parked low.
  initial begin
    forever begin
      #5;
      if (clkEn) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkStats(input string tagName);
    checkOutput({tagName, "_stat_lookups"}, 64'(stat_lookups), 64'(expLookups));
    checkOutput({tagName, "_stat_hits"}, 64'(stat_hits), 64'(expHits));
  endtask

  // Drives one cycle of inputs just after the rising edge and queues the expected lookup result.
  task automatic applyStimulus(input logic lv, input logic [63:0] lpc,
                               input logic uv, input logic [63:0] upc,
                               input logic ut, input logic uu, input logic [63:0] utgt,
                               input logic fl,
                               input logic eh, input logic et, input logic [63:0] en);
    @(posedge clk);
    #1;
    lookup_valid  = lv;
    lookup_pc     = lpc;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_uncond = uu;
    update_target = utgt;
    flush_all     = fl;
    if (lv) begin
      scoreboard.push_back('{hit: eh, taken: et, nextPc: en, pc: lpc});
      expLookups++;
      if (eh) expHits++;
    end
  endtask

  task automatic lookupOnly(input logic [63:0] pc, input logic eh, input logic et, input logic [63:0] en);
    applyStimulus(1'b1, pc, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, eh, et, en);
  endtask

  task automatic updateOnly(input logic [63:0] pc, input logic taken, input logic uncond, input logic [63:0] tgt);
    applyStimulus(1'b0, 64'h0, 1'b1, pc, taken, uncond, tgt, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  // Monitor: every presented lookup is compared against the oldest queued expectation.
  always @(negedge clk) begin
    expect_t e;
    if (reset && lookup_valid) begin
      if (scoreboard.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedLookup: got lookup at 0x%0h, expected none queued", lookup_pc);
      end else begin
        e = scoreboard.pop_front();
        checkOutput($sformatf("hit@%0h", e.pc), 64'(pred_hit), 64'(e.hit));
        checkOutput($sformatf("taken@%0h", e.pc), 64'(pred_taken), 64'(e.taken));
        checkOutput($sformatf("next@%0h", e.pc), pred_next_pc, e.nextPc);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    lookup_valid  = 1'b0;
    lookup_pc     = '0;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_taken  = 1'b0;
    update_uncond = 1'b0;
    update_target = '0;
    flush_all     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    lookupOnly(64'h100, 1'b0, 1'b0, 64'h104);
    idle();
    checkStats("afterReset");

    updateOnly(64'h100, 1'b1, 1'b0, 64'h200);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h200);
    idle();
    checkStats("firstHit");

    repeat (4) updateOnly(64'h100, 1'b0, 1'b0, 64'h7f0);
    lookupOnly(64'h100, 1'b1, 1'b0, 64'h104);
    updateOnly(64'h100, 1'b1, 1'b0, 64'h200);
    lookupOnly(64'h100, 1'b1, 1'b0, 64'h104);
    repeat (4) updateOnly(64'h100, 1'b1, 1'b0, 64'h200);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h200);
    updateOnly(64'h100, 1'b0, 1'b0, 64'h7f0);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h200);
    repeat (2) updateOnly(64'h100, 1'b0, 1'b0, 64'h7f0);
    lookupOnly(64'h100, 1'b1, 1'b0, 64'h104);
    updateOnly(64'h100, 1'b1, 1'b1, 64'h200);
    updateOnly(64'h100, 1'b0, 1'b0, 64'h7f0);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h200);

    updateOnly(64'h140, 1'b1, 1'b0, 64'h300);
    lookupOnly(64'h140, 1'b1, 1'b1, 64'h300);
    lookupOnly(64'h100, 1'b0, 1'b0, 64'h104);
    updateOnly(64'h108, 1'b0, 1'b0, 64'h500);
    lookupOnly(64'h108, 1'b0, 1'b0, 64'h10c);

    applyStimulus(1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 1'b0, 64'h400, 1'b0,
                  1'b0, 1'b0, 64'h104);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h400);

    applyStimulus(1'b0, 64'h0, 1'b1, 64'h180, 1'b1, 1'b0, 64'h600, 1'b1,
                  1'b0, 1'b0, 64'h0);
    lookupOnly(64'h180, 1'b0, 1'b0, 64'h184);
    lookupOnly(64'h100, 1'b0, 1'b0, 64'h104);
    lookupOnly(64'h140, 1'b0, 1'b0, 64'h144);
    lookupOnly(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
    idle();
    checkStats("afterFlush");

    updateOnly(64'h100, 1'b1, 1'b0, 64'h200);
    lookupOnly(64'h100, 1'b1, 1'b1, 64'h200);
    idle();

    @(negedge clk);
    #1 clkEn = 1'b0;
    lookup_valid = 1'b0;
    lookup_pc    = 64'h100;
    #1 checkOutput("preResetHit", 64'(pred_hit), 64'h1);
    reset         = 1'b0;
    update_valid  = 1'b1;
    update_pc     = 64'h100;
    update_taken  = 1'b1;
    update_target = 64'h900;
    #1;
    expLookups = 0;
    expHits    = 0;
    checkOutput("resetHit", 64'(pred_hit), 64'h0);
    checkOutput("resetTaken", 64'(pred_taken), 64'h0);
    checkOutput("resetNext", pred_next_pc, 64'h104);
    checkStats("inReset");
    clkEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b1;
    update_valid = 1'b0;

    idle();
    lookupOnly(64'h100, 1'b0, 1'b0, 64'h104);
    idle();
    checkStats("afterRelease");
    checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised branch target buffer with saturating-counter direction prediction. It sits beside the fetch stage of the pipelined CPU and gives a predicted next PC in the same cycle as the PC lookup. This replaces fixed decode-stage branch resolution with speculative fetch. The execute/decode branch resolver trains it through a one-cycle update port, and a flush port invalidates all entries.

Parameters:
ADDR_W, 64, PC/target width in bits.
ENTRIES, 16, number of direct-mapped entries; must be a power of 2, at least 2.
CNT_W, 2, width of each saturating direction counter; must be at least 1.
STAT_W, 32, width of the performance counters.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
lookup_valid  in  1  a fetch lookup is presented this cycle
lookup_pc  in  ADDR_W  PC being fetched
pred_hit  out  1  lookup_pc matches a valid entry (tag compare)
pred_taken  out  1  pred_hit and counter MSB set
pred_next_pc  out  ADDR_W  pred_taken ? stored target : lookup_pc+4
update_valid  in  1  resolver training event this cycle
update_pc  in  ADDR_W  PC of the resolved branch
update_taken  in  1  actual direction
update_uncond  in  1  branch is unconditional (B/BL/BR)
update_target  in  ADDR_W  actual target
flush_all  in  1  invalidate every entry
stat_lookups  out  STAT_W  count of cycles with lookup_valid
stat_hits  out  STAT_W  count of cycles with lookup_valid and pred_hit

Behaviour:
- IDX_W = $clog2(ENTRIES).
- index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
- Each entry holds: valid, tag, target[ADDR_W], cnt[CNT_W].
- Lookup is combinational from registered state (zero latency), and does not depend on lookup_valid.
  - pc+4 wraps modulo 2^ADDR_W.
- Update is written on the rising clock edge and is visible to lookups from the next cycle.
  - No bypass: a same-cycle lookup at the update index sees the old entry.
- Update on hit (valid and tag match):
  - update_uncond: cnt set to all ones.
  - taken: cnt incremented, saturating at all ones.
  - not taken: cnt decremented, saturating at 0.
  - target overwritten only when taken.
- Update on miss:
  - taken: allocate (replaces any occupant). valid=1, tag and target written. cnt = weakly taken (MSB=1, rest 0), or all ones if uncond.
  - not taken: no change.
- flush_all: every valid bit clears at the next edge.
  - flush_all has priority over a same-cycle update; that update is discarded.
  - Targets, tags and counters need not be cleared.
- Stats:
  - stat_lookups increments when lookup_valid is high.
  - stat_hits increments when lookup_valid and pred_hit are both high.
  - Both saturate at all ones, are unaffected by flush_all, and are cleared only by reset.
- Reset (asynchronous, while reset==0):
  - All valid bits cleared; counters 0; stats 0.
  - Outputs immediately read pred_hit=0 and pred_taken=0, with pred_next_pc = lookup_pc+4.
  - Updates and flushes during reset are ignored.
  - Reset asserted mid-training loses all state; there is no partial-write hazard.
- No X on outputs after reset, for any lookup_pc.

Decomposition:
- Shared package btb_pkg holds:
  - typedef btb_entry_t (valid, tag, target, cnt), parameterised via package constants ADDR_W and IDX_W.
  - Localparams CNT_MAX, CNT_WEAK_T (MSB only), INSTR_BYTES=4.
  - Helper functions btb_index(pc) and btb_tag(pc).
- One sub-module, btb_sat_counter: combinational next-count from cnt, taken and uncond, width CNT_W.
  - Instantiated once on the update path.
- Top level holds the entry array, allocation/flush logic, lookup compare and stat counters.

Test Plan:
- Reset, then lookup 0x100: hit=0, taken=0, next=0x104; stat_lookups=1, stat_hits=0.
- Update 0x100 taken target 0x200, then lookup 0x100: hit=1, taken=1, next=0x200 (cnt=2'b10); stat_hits=1.
- Four not-taken updates at 0x100: cnt goes 10→01→00→00→00, then taken=0, hit=1, next=0x104. Then 5 taken updates give cnt=11 with no overflow. One uncond update from cnt 00 gives cnt=11.
- Aliasing with ENTRIES=16: taken update 0x140 (same index as 0x100, different tag) target 0x300. Lookup 0x140 gives hit, next=0x300; lookup 0x100 then misses. A not-taken update at an unallocated index 0x108 leaves a miss.
- Same-cycle lookup and update at 0x100: lookup returns old entry, new value appears the next cycle. flush_all with a simultaneous taken update at 0x180: all lookups miss next cycle, including 0x180.
- Assert reset mid-stream with clk stopped between edges: pred_hit drops to 0 and stats to 0 without a clock edge. After release, previously trained 0x100 misses.
